// File: rtl/pc_fetch_control.sv
// -----------------------------------------------------------------------------
// pc_fetch_control
//   Fetch-stage program-counter controller. Holds the fetch PC, steps it once
//   per unstalled cycle, redirects it on a taken branch, squashes wrong-path
//   instructions through the IF/ID and ID/EX flush lines, and supports a
//   halt/resume freeze of fetch.
//
// Parameters
//   PC_W         PC / instruction-address width
//   RESET_PC     PC value loaded on reset
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   pcsrc        taken-branch indication from branch resolution
//   bra_pc       branch target, valid while pcsrc=1
//   bra_from_exe 1 = branch resolved in EXE, 0 = resolved in ID
//   stall        hazard stall, hold the PC
//   halt_req     request to freeze fetch
//   resume       leave the halted state
//   pc           current fetch address (registered)
//   if_valid     fetch at pc is a real instruction (registered)
//   flush_ifid   squash IF/ID at the next edge (combinational)
//   flush_idex   squash ID/EX at the next edge (combinational)
//   pc_wrap      one-cycle pulse when the increment wraps to zero (registered)
//   br_count     taken branches accepted, saturating at 255 (registered)
// -----------------------------------------------------------------------------
module pc_fetch_control #(
  parameter int                PC_W     = 6,
  parameter logic [PC_W-1:0]   RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pcsrc,
  input  logic [PC_W-1:0] bra_pc,
  input  logic            bra_from_exe,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            resume,
  output logic [PC_W-1:0] pc,
  output logic            if_valid,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            pc_wrap,
  output logic [7:0]      br_count
);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0] PC_MAX = {PC_W{1'b1}};

  // Saturating 8-bit increment for the branch counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = 8'hFF;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

  state_t state_r;
  state_t state_next_s;

  logic br_take_s;      // accept the branch: load bra_pc, count it
  logic pc_inc_s;       // sequential step of the PC this cycle
  logic flush_ifid_s;
  logic flush_idex_s;
  logic if_valid_next_s;

  // State register; reset always lands in BOOT, dropping any redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; in RUN a branch beats halt, and in HALT resume wins.
  always_comb begin
    state_next_s = ST_BOOT;
    case (state_r)
      ST_BOOT: begin
        state_next_s = ST_RUN;
      end
      ST_RUN: begin
        if (pcsrc) begin
          state_next_s = ST_REDIRECT;
        end else if (halt_req) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        // halt_req is deferred: it is re-evaluated once back in RUN.
        state_next_s = ST_RUN;
      end
      ST_HALT: begin
        if (resume) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_HALT;
        end
      end
      default: begin
        state_next_s = ST_BOOT;
      end
    endcase
  end

  // Per-state control decode: PC update selects and the squash lines.
  always_comb begin
    br_take_s    = 1'b0;
    pc_inc_s     = 1'b0;
    flush_ifid_s = 1'b0;
    flush_idex_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (pcsrc) begin
          // Younger instruction in IF/ID is always wrong-path; the one in
          // ID/EX is only wrong-path when the branch resolved in EXE.
          br_take_s    = 1'b1;
          flush_ifid_s = 1'b1;
          flush_idex_s = bra_from_exe;
        end else if (halt_req) begin
          pc_inc_s = 1'b0;
        end else if (stall) begin
          pc_inc_s = 1'b0;
        end else begin
          pc_inc_s = 1'b1;
        end
      end
      ST_REDIRECT: begin
        // pcsrc here belongs to a squashed slot and is ignored.
        if (stall) begin
          pc_inc_s = 1'b0;
        end else begin
          pc_inc_s = 1'b1;
        end
      end
      ST_BOOT: begin
        pc_inc_s = 1'b0;
      end
      ST_HALT: begin
        pc_inc_s = 1'b0;
      end
      default: begin
        pc_inc_s = 1'b0;
      end
    endcase
  end

  // Fetch is valid in RUN and REDIRECT; a stalled fetch stays valid.
  always_comb begin
    if_valid_next_s = 1'b0;
    if ((state_next_s == ST_RUN) || (state_next_s == ST_REDIRECT)) begin
      if_valid_next_s = 1'b1;
    end else begin
      if_valid_next_s = 1'b0;
    end
  end

  // Gate with rst_n so the squash lines are quiet while reset is held.
  assign flush_ifid = flush_ifid_s & rst_n;
  assign flush_idex = flush_idex_s & rst_n;

  // PC, wrap pulse, branch counter and fetch-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      pc_wrap  <= 1'b0;
      br_count <= 8'd0;
    end else begin
      if_valid <= if_valid_next_s;
      if (br_take_s) begin
        pc <= bra_pc;
      end else if (pc_inc_s) begin
        pc <= pc + PC_ONE;
      end else begin
        pc <= pc;
      end
      // Only the sequential step can wrap; a branch to zero does not.
      pc_wrap <= pc_inc_s && (pc == PC_MAX);
      if (br_take_s) begin
        br_count <= sat_inc8(br_count);
      end else begin
        br_count <= br_count;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_control.sv
module tb_pc_fetch_control;

  localparam int S_BOOT  = 0;
  localparam int S_RUN   = 1;
  localparam int S_REDIR = 2;
  localparam int S_HALT  = 3;

  logic       clk;
  logic       rst_n;
  logic       pcsrc;
  logic [5:0] bra_pc;
  logic       bra_from_exe;
  logic       stall;
  logic       halt_req;
  logic       resume;
  logic [5:0] pc;
  logic       if_valid;
  logic       flush_ifid;
  logic       flush_idex;
  logic       pc_wrap;
  logic [7:0] br_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0] pc;
    logic       if_valid;
    logic       wrap;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  // reference model state
  int         m_st;
  logic [5:0] m_pc;
  logic [7:0] m_cnt;

  pc_fetch_control #(.PC_W(6), .RESET_PC(6'd0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pcsrc        (pcsrc),
    .bra_pc       (bra_pc),
    .bra_from_exe (bra_from_exe),
    .stall        (stall),
    .halt_req     (halt_req),
    .resume       (resume),
    .pc           (pc),
    .if_valid     (if_valid),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .pc_wrap      (pc_wrap),
    .br_count     (br_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st  = S_BOOT;
    m_pc  = 6'd0;
    m_cnt = 8'd0;
  endtask

  // One clock cycle: drive, check flushes, predict, clock, compare.
  task automatic cyc(input logic p, input logic [5:0] b, input logic e,
                     input logic s, input logic h, input logic r);
    exp_t x;
    logic fi;
    logic fx;
    int   n_st;
    pcsrc = p; bra_pc = b; bra_from_exe = e; stall = s; halt_req = h; resume = r;
    #1;
    fi = (m_st == S_RUN) && p;
    fx = fi && e;
    chk("flush_ifid", 32'(flush_ifid), 32'(fi));
    chk("flush_idex", 32'(flush_idex), 32'(fx));
    x.wrap = 1'b0;
    n_st = m_st;
    if (m_st == S_BOOT) begin
      n_st = S_RUN;
    end else if (m_st == S_RUN) begin
      if (p) begin
        m_pc = b;
        if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        n_st = S_REDIR;
      end else if (h) begin
        n_st = S_HALT;
      end else if (!s) begin
        x.wrap = (m_pc == 6'd63);
        m_pc = m_pc + 6'd1;
      end
    end else if (m_st == S_REDIR) begin
      n_st = S_RUN;
      if (!s) begin
        x.wrap = (m_pc == 6'd63);
        m_pc = m_pc + 6'd1;
      end
    end else begin
      if (r) n_st = S_RUN;
    end
    m_st = n_st;
    x.pc = m_pc;
    x.cnt = m_cnt;
    x.if_valid = (m_st == S_RUN) || (m_st == S_REDIR);
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    chk("pc",       32'(pc),       32'(x.pc));
    chk("if_valid", 32'(if_valid), 32'(x.if_valid));
    chk("pc_wrap",  32'(pc_wrap),  32'(x.wrap));
    chk("br_count", 32'(br_count), 32'(x.cnt));
  endtask

  task automatic idle();
    cyc(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; pcsrc = 1'b0; bra_pc = 6'd0; bra_from_exe = 1'b0;
    stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
    model_reset();
    #2;
    chk("rst_pc",       32'(pc),         32'd0);
    chk("rst_if_valid", 32'(if_valid),   32'd0);
    chk("rst_flush",    32'(flush_ifid), 32'd0);
    chk("rst_wrap",     32'(pc_wrap),    32'd0);
    chk("rst_cnt",      32'(br_count),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // boot cycle then pc = 0,1,2,3
    idle();
    chk("boot_pc0", 32'(pc), 32'd0);
    chk("boot_valid", 32'(if_valid), 32'd1);
    for (int i = 0; i < 3; i++) idle();
    chk("run_pc3", 32'(pc), 32'd3);

    // ID-resolved branch to 20
    cyc(1'b1, 6'd20, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("id_br_pc", 32'(pc), 32'd20);
    chk("id_br_cnt", 32'(br_count), 32'd1);
    idle();
    chk("id_br_pc21", 32'(pc), 32'd21);

    // EXE-resolved branch with stall, then ignored pcsrc in REDIRECT
    cyc(1'b1, 6'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("exe_br_pc", 32'(pc), 32'd9);
    cyc(1'b1, 6'd30, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("redir_pc", 32'(pc), 32'd10);
    chk("redir_cnt", 32'(br_count), 32'd2);

    // stall held three cycles holds the PC
    for (int i = 0; i < 3; i++) cyc(1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stall_pc", 32'(pc), 32'd10);
    idle();

    // wrap from 63
    for (int i = 0; i < 70 && m_pc != 6'd63; i++) idle();
    chk("pre_wrap_pc", 32'(pc), 32'd63);
    idle();
    chk("wrap_pc", 32'(pc), 32'd0);
    chk("wrap_pulse", 32'(pc_wrap), 32'd1);
    idle();
    chk("wrap_clear", 32'(pc_wrap), 32'd0);
    cyc(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("br0_wrap", 32'(pc_wrap), 32'd0);
    idle();

    // halt at pc 7
    for (int i = 0; i < 70 && m_pc != 6'd7; i++) idle();
    cyc(1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("halt_pc", 32'(pc), 32'd7);
    chk("halt_valid", 32'(if_valid), 32'd0);
    cyc(1'b1, 6'd40, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("halt_br_pc", 32'(pc), 32'd7);
    cyc(1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("resume_pc", 32'(pc), 32'd7);
    chk("resume_valid", 32'(if_valid), 32'd1);
    idle();
    chk("resume_pc8", 32'(pc), 32'd8);

    // counter saturation
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 6'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
    end
    chk("sat_cnt", 32'(br_count), 32'd255);

    // reset asserted in REDIRECT
    cyc(1'b1, 6'd33, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_pc", 32'(pc), 32'd33);
    pcsrc = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_pc",    32'(pc),         32'd0);
    chk("mid_rst_cnt",   32'(br_count),   32'd0);
    chk("mid_rst_valid", 32'(if_valid),   32'd0);
    chk("mid_rst_flush", 32'(flush_ifid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 6'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_pc", 32'(pc), 32'd0);
    idle();
    chk("post_rst_pc1", 32'(pc), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
